// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit that stalls the pipeline until its result is ready
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [XLEN-1:0]     operand_a,
  input  logic [XLEN-1:0]     operand_b,
  input  logic [REG_ID_W-1:0] rd_id,
  input  logic                flush,
  output logic                busy,
  output logic                stall,
  output logic                result_valid,
  output logic [XLEN-1:0]     result,
  output logic [REG_ID_W-1:0] result_rd
);
  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
  localparam int CW = $clog2(XLEN);
  state_t state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mag_q, mag_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [REG_ID_W-1:0] rd_q, rd_d, result_rd_q, result_rd_d;
  logic neg_q, neg_d, rneg_q, rneg_d;
  logic sa, sb, div_zero, div_ovf, is_mul, last;
  logic [XLEN-1:0] abs_a, abs_b, quo, rem;
  logic [2*XLEN-1:0] prod;
  logic [XLEN+1:0] add_x, add_y, sum;
  assign sa = (op == 3'd1) | (op == 3'd2) | (op[2] & ~op[0]);
  assign sb = (op == 3'd1) | (op[2] & ~op[0]);
  assign abs_a = (sa & operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign abs_b = (sb & operand_b[XLEN-1]) ? -operand_b : operand_b;
  assign div_zero = operand_b == '0;
  assign div_ovf = ~op[0] & (operand_a == {1'b1, {(XLEN-1){1'b0}}}) & (&operand_b);
  assign is_mul = state_q == MUL_RUN;
  assign last = cnt_q == CW'(XLEN-1);
  // Shared adder: multiply accumulates hi+mag, divide trial-subtracts mag from the shifted remainder
  assign add_x = is_mul ? {2'b00, hi_q} : {1'b0, hi_q, lo_q[XLEN-1]};
  assign add_y = is_mul ? (lo_q[0] ? {2'b00, mag_q} : '0) : ~{2'b00, mag_q};
  assign sum = add_x + add_y + {{(XLEN+1){1'b0}}, ~is_mul};
  always_comb begin
    state_d = state_q;
    hi_d = hi_q;
    lo_d = lo_q;
    mag_d = mag_q;
    cnt_d = cnt_q;
    op_d = op_q;
    rd_d = rd_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    result_d = result_q;
    result_rd_d = result_rd_q;
    prod = '0;
    quo = '0;
    rem = '0;
    case (state_q)
      IDLE: if (start && !flush) begin
        op_d = op;
        rd_d = rd_id;
        cnt_d = '0;
        hi_d = '0;
        neg_d = (sa & operand_a[XLEN-1]) ^ (sb & operand_b[XLEN-1]);
        rneg_d = sa & operand_a[XLEN-1];
        lo_d = op[2] ? abs_a : abs_b;
        mag_d = op[2] ? abs_b : abs_a;
        state_d = !op[2] ? MUL_RUN : (div_zero || div_ovf) ? DONE : DIV_RUN;
        if (op[2] && (div_zero || div_ovf)) begin
          result_d = div_zero ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);
          result_rd_d = rd_id;
        end
      end
      MUL_RUN, DIV_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_mul) {hi_d, lo_d} = {sum[XLEN:1], sum[0], lo_q[XLEN-1:1]};
        else if (sum[XLEN+1]) {hi_d, lo_d} = {hi_q[XLEN-2:0], lo_q, 1'b0};
        else {hi_d, lo_d} = {sum[XLEN-1:0], lo_q[XLEN-2:0], 1'b1};
        prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        quo = neg_q ? -lo_d : lo_d;
        rem = rneg_q ? -hi_d : hi_d;
        if (flush) state_d = IDLE;
        else if (last) begin
          state_d = DONE;
          result_d = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
          result_rd_d = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q <= '0;
      lo_q <= '0;
      mag_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      result_q <= '0;
      result_rd_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      mag_q <= mag_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      rd_q <= rd_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      result_q <= result_d;
      result_rd_q <= result_rd_d;
    end
  end
  assign busy = state_q != IDLE;
  assign stall = !rst & ((start & state_q == IDLE & !flush) | state_q == MUL_RUN | state_q == DIV_RUN);
  assign result_valid = state_q == DONE;
  assign result = result_q;
  assign result_rd = result_rd_q;
endmodule
